// File: rtl/gpu_io_pkg.sv
// Shared definitions for the board input path: read-port register
// selects, the ID word and the read handshake state type.
package gpu_io_pkg;

  // Read-port register selects carried on rd_sel
  localparam logic [1:0] SEL_SW  = 2'd0;
  localparam logic [1:0] SEL_KEY = 2'd1;
  localparam logic [1:0] SEL_EVT = 2'd2;
  localparam logic [1:0] SEL_ID  = 2'd3;

  // Identification word returned for SEL_ID
  localparam logic [15:0] ID_WORD = 16'h600D;

  // Four-phase read handshake states
  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } rd_state_e;

  // Width of a counter that must reach `cycles`; never narrower than one bit
  function automatic int unsigned cnt_width(input int unsigned cycles);
    if (cycles < 1) begin
      return 1;
    end
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One input bit: two-flop synchroniser followed by a run-length debouncer.
// The stable level only changes after DEBOUNCE_CYCLES consecutive edges on
// which the synchronised level disagrees with it.
module debounce_bit
  import gpu_io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic stable_o,
  output logic rise_o
);

  localparam int unsigned        CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  // Counter value seen on the edge that completes the mismatch run
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta_q;
  logic             sync_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             stable_q;
  logic             stable_d;

  // Count consecutive disagreeing edges; accept the new level on the last one
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (sync_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync_q;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchroniser, counter and stable level registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      meta_q   <= raw_i;
      sync_q   <= meta_q;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable_o = stable_q;
  // High during the cycle whose closing edge turns the stable level 0 -> 1,
  // so the owner can latch an event on the same edge the level changes.
  assign rise_o   = stable_d & ~stable_q;

endmodule

// File: rtl/board_input_if.sv
// Board-to-core input path: debounced switches and push-buttons, sticky
// key-press flags, and a four-phase request/acknowledge read port.
module board_input_if
  import gpu_io_pkg::*;
#(
  parameter int unsigned SW_WIDTH        = 9,
  parameter int unsigned KEY_WIDTH       = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned DATA_WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [SW_WIDTH-1:0]   sw_raw,
  input  logic [KEY_WIDTH-1:0]  key_n_raw,
  input  logic                  rd_req,
  input  logic [1:0]            rd_sel,
  output logic                  rd_ack,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [SW_WIDTH-1:0]   sw_state,
  output logic [KEY_WIDTH-1:0]  key_state,
  output logic [KEY_WIDTH-1:0]  key_event
);

  logic [SW_WIDTH-1:0]   sw_stable;
  logic [SW_WIDTH-1:0]   sw_rise_unused;
  logic [KEY_WIDTH-1:0]  key_stable;
  logic [KEY_WIDTH-1:0]  key_rise;

  logic [KEY_WIDTH-1:0]  key_event_q;
  logic [KEY_WIDTH-1:0]  key_event_d;

  rd_state_e             state_q;
  rd_state_e             state_d;
  logic                  rd_ack_q;
  logic                  rd_ack_d;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [DATA_WIDTH-1:0] rd_data_d;
  logic [DATA_WIDTH-1:0] rd_mux;
  logic                  evt_clr;

  // Switches: level only, no events are derived from them
  for (genvar gi = 0; gi < SW_WIDTH; gi++) begin : g_sw
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_db (
      .clk      (clk),
      .rst_n    (rst_n),
      .raw_i    (sw_raw[gi]),
      .stable_o (sw_stable[gi]),
      .rise_o   (sw_rise_unused[gi])
    );
  end

  // Keys: pins are active-low, so invert before synchronising; the reset
  // level of every stage therefore means "released".
  for (genvar gi = 0; gi < KEY_WIDTH; gi++) begin : g_key
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_db (
      .clk      (clk),
      .rst_n    (rst_n),
      .raw_i    (~key_n_raw[gi]),
      .stable_o (key_stable[gi]),
      .rise_o   (key_rise[gi])
    );
  end

  // Select the word a new request will capture
  always_comb begin
    rd_mux = '0;
    case (rd_sel)
      SEL_SW:  rd_mux = DATA_WIDTH'(sw_stable);
      SEL_KEY: rd_mux = DATA_WIDTH'(key_stable);
      SEL_EVT: rd_mux = DATA_WIDTH'(key_event_q);
      SEL_ID:  rd_mux = DATA_WIDTH'(ID_WORD);
      default: rd_mux = '0;
    endcase
  end

  // Read handshake: capture once on request entry, hold until request drops
  always_comb begin
    state_d   = state_q;
    rd_ack_d  = rd_ack_q;
    rd_data_d = rd_data_q;
    evt_clr   = 1'b0;
    case (state_q)
      IDLE: begin
        rd_ack_d = 1'b0;
        if (rd_req) begin
          state_d   = ACK;
          rd_ack_d  = 1'b1;
          rd_data_d = rd_mux;
          evt_clr   = (rd_sel == SEL_EVT);
        end
      end
      ACK: begin
        rd_ack_d = 1'b1;
        if (!rd_req) begin
          state_d  = IDLE;
          rd_ack_d = 1'b0;
        end
      end
      default: begin
        state_d  = IDLE;
        rd_ack_d = 1'b0;
      end
    endcase
  end

  // Read FSM with registered acknowledge and data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rd_ack_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      rd_ack_q  <= rd_ack_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Sticky press flags: a clear-on-read wipes old flags, but a press that
  // becomes stable on the very same edge survives the clear.
  always_comb begin
    key_event_d = (evt_clr ? '0 : key_event_q) | key_rise;
  end

  // Press-event register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_event_q <= '0;
    end else begin
      key_event_q <= key_event_d;
    end
  end

  assign rd_ack    = rd_ack_q;
  assign rd_data   = rd_data_q;
  assign sw_state  = sw_stable;
  assign key_state = key_stable;
  assign key_event = key_event_q;

endmodule

// File: tb/tb_board_input_if.sv
// Bench for board_input_if with a short debounce window. A window-based
// reference model predicts every output each cycle; directed steps add
// absolute expectations for the key scenarios.
module tb_board_input_if;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [8:0]  sw_raw = '0;
  logic [3:0]  key_n_raw = 4'hF;
  logic        rd_req = 1'b0;
  logic [1:0]  rd_sel = 2'd0;
  logic        rd_ack;
  logic [15:0] rd_data;
  logic [8:0]  sw_state;
  logic [3:0]  key_state;
  logic [3:0]  key_event;

  int errors = 0;
  int checks = 0;

  board_input_if #(
    .SW_WIDTH        (9),
    .KEY_WIDTH       (4),
    .DEBOUNCE_CYCLES (D),
    .DATA_WIDTH      (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw_raw    (sw_raw),
    .key_n_raw (key_n_raw),
    .rd_req    (rd_req),
    .rd_sel    (rd_sel),
    .rd_ack    (rd_ack),
    .rd_data   (rd_data),
    .sw_state  (sw_state),
    .key_state (key_state),
    .key_event (key_event)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // win[D+1] is the newest raw sample; a level is accepted once the D samples
  // that have passed through the two sync stages all disagree with it.
  logic [8:0]  m_sw_win  [D+2];
  logic [3:0]  m_key_win [D+2];
  logic [8:0]  m_sw, m_sw_next, sw_ones, sw_any;
  logic [3:0]  m_key, m_key_next, key_ones, key_any;
  logic [3:0]  m_evt, m_evt_next;
  logic        m_ack, m_ack_next;
  logic [15:0] m_data, m_data_next;

  always_comb begin
    sw_ones  = '1;
    sw_any   = '0;
    key_ones = '1;
    key_any  = '0;
    for (int k = 1; k <= D; k++) begin
      sw_ones  = sw_ones & m_sw_win[k];
      sw_any   = sw_any | m_sw_win[k];
      key_ones = key_ones & m_key_win[k];
      key_any  = key_any | m_key_win[k];
    end
    m_sw_next  = (m_sw & sw_any) | (~m_sw & sw_ones);
    m_key_next = (m_key & key_any) | (~m_key & key_ones);
    m_ack_next  = m_ack;
    m_data_next = m_data;
    m_evt_next  = m_evt | (m_key_next & ~m_key);
    if (!m_ack && rd_req) begin
      m_ack_next = 1'b1;
      case (rd_sel)
        2'd0:    m_data_next = {7'd0, m_sw};
        2'd1:    m_data_next = {12'd0, m_key};
        2'd2:    m_data_next = {12'd0, m_evt};
        default: m_data_next = 16'h600D;
      endcase
      if (rd_sel == 2'd2) m_evt_next = m_key_next & ~m_key;
    end else if (m_ack && !rd_req) begin
      m_ack_next = 1'b0;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < D + 2; k++) begin
        m_sw_win[k]  <= '0;
        m_key_win[k] <= '0;
      end
      m_sw   <= '0;
      m_key  <= '0;
      m_evt  <= '0;
      m_ack  <= 1'b0;
      m_data <= '0;
    end else begin
      for (int k = 0; k < D + 1; k++) begin
        m_sw_win[k]  <= m_sw_win[k+1];
        m_key_win[k] <= m_key_win[k+1];
      end
      m_sw_win[D+1]  <= sw_raw;
      m_key_win[D+1] <= ~key_n_raw;
      m_sw   <= m_sw_next;
      m_key  <= m_key_next;
      m_evt  <= m_evt_next;
      m_ack  <= m_ack_next;
      m_data <= m_data_next;
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    check("model_sw_state", 32'(sw_state), 32'(m_sw));
    check("model_key_state", 32'(key_state), 32'(m_key));
    check("model_key_event", 32'(key_event), 32'(m_evt));
    check("model_rd_ack", 32'(rd_ack), 32'(m_ack));
    check("model_rd_data", 32'(rd_data), 32'(m_data));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int sw_hold;
  int key_hold;

  initial begin
    // Reset and ID read
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("reset_sw_state", 32'(sw_state), 32'h0);
    check("reset_key_state", 32'(key_state), 32'h0);
    check("reset_key_event", 32'(key_event), 32'h0);
    check("reset_rd_ack", 32'(rd_ack), 32'h0);
    check("reset_rd_data", 32'(rd_data), 32'h0);
    rst_n = 1'b1;
    steps(2);
    check("idle_outputs", {rd_ack, rd_data, sw_state, key_state, key_event}, 32'h0);
    rd_sel = 2'd3; rd_req = 1'b1;
    step();
    check("id_ack_rise", 32'(rd_ack), 32'h1);
    check("id_data", 32'(rd_data), 32'h600D);
    step();
    check("id_ack_held", 32'(rd_ack), 32'h1);
    rd_req = 1'b0;
    step();
    check("id_ack_fall", 32'(rd_ack), 32'h0);
    check("id_data_kept", 32'(rd_data), 32'h600D);

    // Switch latency and glitch rejection
    sw_raw = 9'h1A5;
    steps(5);
    check("sw_latency_early", 32'(sw_state), 32'h0);
    step();
    check("sw_latency_exact", 32'(sw_state), 32'h1A5);
    sw_raw = 9'h1FF;
    steps(3);
    sw_raw = 9'h1A5;
    steps(8);
    check("sw_glitch_ignored", 32'(sw_state), 32'h1A5);

    // Key press, event read and clear
    key_n_raw = 4'b1011;
    steps(5);
    check("key_latency_early", 32'(key_state), 32'h0);
    step();
    check("key_state_press", 32'(key_state), 32'h4);
    check("key_event_press", 32'(key_event), 32'h4);
    rd_sel = 2'd2; rd_req = 1'b1;
    step();
    check("evt_read1", 32'(rd_data), 32'h0004);
    check("evt_cleared", 32'(key_event), 32'h0);
    rd_req = 1'b0;
    step();
    rd_req = 1'b1;
    step();
    check("evt_read2", 32'(rd_data), 32'h0000);
    check("key_state_kept", 32'(key_state), 32'h4);
    rd_req = 1'b0;
    step();

    // Release produces no event; re-press KEY[2], then KEY[0] lands on a capture edge
    key_n_raw = 4'b1111;
    steps(8);
    check("release_no_event", 32'(key_event), 32'h0);
    key_n_raw = 4'b1011;
    steps(6);
    check("repress_event", 32'(key_event), 32'h4);
    key_n_raw = 4'b1010;
    steps(5);
    rd_sel = 2'd2; rd_req = 1'b1;
    step();
    check("same_edge_data", 32'(rd_data), 32'h0004);
    check("same_edge_retained", 32'(key_event), 32'h1);
    rd_req = 1'b0;
    step();
    rd_req = 1'b1;
    step();
    check("same_edge_next_read", 32'(rd_data), 32'h0001);
    rd_req = 1'b0;
    step();

    // Long request with rd_sel toggling: single capture, no clear
    key_n_raw = 4'b1111;
    steps(8);
    key_n_raw = 4'b1101;
    steps(6);
    check("key1_event", 32'(key_event), 32'h2);
    rd_sel = 2'd0; rd_req = 1'b1;
    step();
    check("long_ack_rise", 32'(rd_ack), 32'h1);
    check("long_data", 32'(rd_data), 32'h01A5);
    for (int i = 0; i < 4; i++) begin
      rd_sel = (i % 2 == 0) ? 2'd2 : 2'd3;
      step();
      check("long_ack_held", 32'(rd_ack), 32'h1);
      check("long_data_stable", 32'(rd_data), 32'h01A5);
      check("long_no_clear", 32'(key_event), 32'h2);
    end
    rd_req = 1'b0;
    step();
    check("long_ack_fall", 32'(rd_ack), 32'h0);

    // Reset asserted while acknowledging
    rd_sel = 2'd3; rd_req = 1'b1;
    step();
    check("pre_reset_ack", 32'(rd_ack), 32'h1);
    rst_n = 1'b0;
    #1;
    check("async_reset_ack", 32'(rd_ack), 32'h0);
    check("async_reset_event", 32'(key_event), 32'h0);
    check("async_reset_levels", {sw_state, key_state}, 32'h0);
    rd_req = 1'b0;
    steps(2);
    rst_n = 1'b1;
    // KEY[1] is still held, so it must come back as a press event
    steps(6);
    check("held_through_reset", 32'(key_event), 32'h2);

    // Randomised phase against the model
    sw_hold  = 0;
    key_hold = 0;
    for (int c = 0; c < 1500; c++) begin
      if (sw_hold == 0) begin
        sw_raw  = 9'($urandom);
        sw_hold = $urandom_range(1, 9);
      end
      sw_hold--;
      if (key_hold == 0) begin
        key_n_raw = key_n_raw ^ (4'b1 << $urandom_range(0, 3));
        key_hold  = $urandom_range(1, 9);
      end
      key_hold--;
      if ($urandom_range(0, 2) == 0) rd_req = ~rd_req;
      rd_sel = 2'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
